// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register numbers for rename.
// One pop port (allocation) and two push ports (retire, flush). Storage is
// preloaded with INIT_BASE..INIT_BASE+DEPTH-1 on reset.
//
// Allocation handshake: alloc_req is the request and alloc_gnt the response.
// Both are sampled in the same cycle. alloc_PR is the transferred value when
// alloc_gnt=1. alloc_gnt=1 exactly when alloc_req=1 and the list is not empty.
// The pop commits at the next rising edge. There is no back-pressure beyond
// alloc_gnt. A refused request must simply be held or reissued by rename.
module free_list #(
    parameter int PR_WIDTH  = 6,
    parameter int DEPTH     = 32,
    parameter int INIT_BASE = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_req,
    output logic [PR_WIDTH-1:0]          alloc_PR,
    output logic                         alloc_gnt,
    input  logic                         retire_reg,
    input  logic [PR_WIDTH-1:0]          PR_old_RT,
    input  logic                         rd_flush,
    input  logic [PR_WIDTH-1:0]          PR_new_flush,
    output logic [$clog2(DEPTH+1)-1:0]   free_count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [PR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;

    // Write ports. Port A takes the first accepted push, port B the second.
    logic                wr_a_en, wr_b_en;
    logic [PTR_W-1:0]    wr_a_addr, wr_b_addr;
    logic [PR_WIDTH-1:0] wr_a_data, wr_b_data;

    logic                pop;
    logic                ret_acc, fl_acc;
    logic [CNT_W-1:0]    cnt_after_pop, cnt_after_ret;

    // Modulo-DEPTH pointer increment; also correct for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + PTR_W'(1);
    endfunction

    // Outputs come straight from registered state; only alloc_gnt also sees alloc_req.
    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_C);
    assign free_count = count_q;
    assign overflow   = overflow_q;
    assign alloc_PR   = mem_q[head_q];
    assign alloc_gnt  = pop;
    assign pop        = alloc_req & ~empty;

    // Next state: pop is ordered first, then the retire push, then the flush push.
    // Each push checks space against the running count.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        overflow_d    = overflow_q;
        wr_a_en       = 1'b0;
        wr_b_en       = 1'b0;
        wr_a_addr     = tail_q;
        wr_b_addr     = ptr_inc(tail_q);
        wr_a_data     = PR_old_RT;
        wr_b_data     = PR_new_flush;

        cnt_after_pop = count_q - CNT_W'(pop);
        ret_acc       = retire_reg & (cnt_after_pop < DEPTH_C);
        cnt_after_ret = cnt_after_pop + CNT_W'(ret_acc);
        fl_acc        = rd_flush & (cnt_after_ret < DEPTH_C);
        count_d       = cnt_after_ret + CNT_W'(fl_acc);

        if (pop) begin
            head_d = ptr_inc(head_q);
        end

        if (ret_acc && fl_acc) begin
            wr_a_en = 1'b1;
            wr_b_en = 1'b1;
            tail_d  = ptr_inc(ptr_inc(tail_q));
        end else if (ret_acc || fl_acc) begin
            wr_a_en   = 1'b1;
            wr_a_data = ret_acc ? PR_old_RT : PR_new_flush;
            tail_d    = ptr_inc(tail_q);
        end

        if ((retire_reg && !ret_acc) || (rd_flush && !fl_acc)) begin
            overflow_d = 1'b1;
        end
    end

    // State and storage registers; reset reloads the initial free PR set.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= DEPTH_C;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PR_WIDTH'(INIT_BASE + i);
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (wr_a_en) mem_q[wr_a_addr] <= wr_a_data;
            if (wr_b_en) mem_q[wr_b_addr] <= wr_b_data;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus a randomized run, all checked
// against a queue-based model of the free list.
module tb_free_list;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alloc_req = 1'b0;
    logic [5:0] alloc_PR;
    logic       alloc_gnt;
    logic       retire_reg = 1'b0;
    logic [5:0] PR_old_RT = '0;
    logic       rd_flush = 1'b0;
    logic [5:0] PR_new_flush = '0;
    logic [5:0] free_count;
    logic       empty;
    logic       full;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: contents of the free list in allocation order, plus sticky overflow.
    logic [5:0] exp_q[$];
    logic       model_ovf = 1'b0;

    free_list #(.PR_WIDTH(6), .DEPTH(32), .INIT_BASE(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_PR     (alloc_PR),
        .alloc_gnt    (alloc_gnt),
        .retire_reg   (retire_reg),
        .PR_old_RT    (PR_old_RT),
        .rd_flush     (rd_flush),
        .PR_new_flush (PR_new_flush),
        .free_count   (free_count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow)
    );

    // Clock
    always #5 clk = ~clk;

    // Drive one cycle's requests, then let combinational outputs settle.
    task automatic drive(input logic req, input logic ret, input logic [5:0] ret_pr,
                         input logic fl, input logic [5:0] fl_pr);
        alloc_req    = req;
        retire_reg   = ret;
        PR_old_RT    = ret_pr;
        rd_flush     = fl;
        PR_new_flush = fl_pr;
        #1;
    endtask

    // Advance one clock edge, update the model from the applied requests, clear requests.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
            model_ovf = 1'b0;
        end else begin
            if (alloc_req && exp_q.size() > 0) void'(exp_q.pop_front());
            if (retire_reg) begin
                if (exp_q.size() < 32) exp_q.push_back(PR_old_RT);
                else model_ovf = 1'b1;
            end
            if (rd_flush) begin
                if (exp_q.size() < 32) exp_q.push_back(PR_new_flush);
                else model_ovf = 1'b1;
            end
        end
        #1;
        rst = 1'b0; alloc_req = 1'b0; retire_reg = 1'b0; rd_flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (alloc_PR !== 6'd32) begin n_fail++; $display("FAIL reset_alloc_PR got=%0d exp=32", alloc_PR); end
        n_checks++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL reset_count got=%0d exp=32", free_count); end
        n_checks++; if ({full, empty, overflow} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got=%b exp=100", {full, empty, overflow}); end
        for (int i = 0; i < 10; i++) begin drive(1, 0, 0, 0, 0); tick(); end
        n_checks++; if (free_count !== 6'd22) begin n_fail++; $display("FAIL ten_allocs_count got=%0d exp=22", free_count); end
        do_reset();
        n_checks++; if (alloc_PR !== 6'd32) begin n_fail++; $display("FAIL rereset_alloc_PR got=%0d exp=32", alloc_PR); end
        n_checks++; if (free_count !== 6'd32) begin n_fail++; $display("FAIL rereset_count got=%0d exp=32", free_count); end
        n_checks++; if ({full, empty, overflow} !== 3'b100) begin n_fail++; $display("FAIL rereset_flags got=%b exp=100", {full, empty, overflow}); end
        drive(1, 0, 0, 0, 0);
        n_checks++; if (alloc_gnt !== 1'b1) begin n_fail++; $display("FAIL reset_gnt got=%b exp=1", alloc_gnt); end
        drive(0, 0, 0, 0, 0);
        n_checks++; if (alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_nogrant got=%b exp=0", alloc_gnt); end
    endtask

    task automatic test_drain();
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            drive(1, 0, 0, 0, 0);
            n_checks++; if (alloc_gnt !== 1'b1 || alloc_PR !== 6'(31 + k)) begin
                n_fail++; $display("FAIL drain_grant k=%0d got gnt=%b pr=%0d exp gnt=1 pr=%0d", k, alloc_gnt, alloc_PR, 31 + k);
            end
            tick();
        end
        n_checks++; if (empty !== 1'b1 || free_count !== 6'd0) begin n_fail++; $display("FAIL drain_empty got empty=%b cnt=%0d exp 1/0", empty, free_count); end
        drive(1, 0, 0, 0, 0);
        n_checks++; if (alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL drain_refuse got=%b exp=0", alloc_gnt); end
        tick();
        n_checks++; if (free_count !== 6'd0 || full !== 1'b0) begin n_fail++; $display("FAIL drain_stay got cnt=%0d full=%b exp 0/0", free_count, full); end
    endtask

    task automatic test_fifo_order();
        drive(0, 1, 6'd5, 0, 0); tick();
        drive(0, 1, 6'd6, 0, 0); tick();
        n_checks++; if (free_count !== 6'd2) begin n_fail++; $display("FAIL order_count2 got=%0d exp=2", free_count); end
        drive(1, 0, 0, 0, 0);
        n_checks++; if (alloc_gnt !== 1'b1 || alloc_PR !== 6'd5) begin n_fail++; $display("FAIL order_first got gnt=%b pr=%0d exp 1/5", alloc_gnt, alloc_PR); end
        tick();
        n_checks++; if (free_count !== 6'd1) begin n_fail++; $display("FAIL order_count1 got=%0d exp=1", free_count); end
        drive(1, 0, 0, 0, 0);
        n_checks++; if (alloc_PR !== 6'd6) begin n_fail++; $display("FAIL order_second got=%0d exp=6", alloc_PR); end
        tick();
        n_checks++; if (free_count !== 6'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL order_count0 got cnt=%0d empty=%b exp 0/1", free_count, empty); end
        // Alloc while empty with a same-cycle push: refused, push lands.
        drive(1, 1, 6'd17, 0, 0);
        n_checks++; if (alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL nobypass_gnt got=%b exp=0", alloc_gnt); end
        tick();
        n_checks++; if (free_count !== 6'd1 || alloc_PR !== 6'd17) begin n_fail++; $display("FAIL nobypass_after got cnt=%0d pr=%0d exp 1/17", free_count, alloc_PR); end
        drive(1, 0, 0, 0, 0); tick();
    endtask

    task automatic test_simultaneous();
        drive(0, 1, 6'd50, 0, 0); tick();
        drive(1, 1, 6'd7, 1, 6'd40);
        n_checks++; if (alloc_gnt !== 1'b1 || alloc_PR !== 6'd50) begin n_fail++; $display("FAIL simul_grant got gnt=%b pr=%0d exp 1/50", alloc_gnt, alloc_PR); end
        tick();
        n_checks++; if (free_count !== 6'd2) begin n_fail++; $display("FAIL simul_count got=%0d exp=2", free_count); end
        drive(1, 0, 0, 0, 0);
        n_checks++; if (alloc_PR !== 6'd7) begin n_fail++; $display("FAIL simul_next1 got=%0d exp=7", alloc_PR); end
        tick();
        drive(1, 0, 0, 0, 0);
        n_checks++; if (alloc_PR !== 6'd40) begin n_fail++; $display("FAIL simul_next2 got=%0d exp=40", alloc_PR); end
        tick();
    endtask

    task automatic test_wrap();
        // Bring the tail to the last slot by pushing until the model's tail reaches it.
        // The list is empty here with tail at slot 6; 25 pushes reach slot 31.
        for (int i = 0; i < 25; i++) begin drive(0, 1, 6'(i), 0, 0); tick(); end
        drive(0, 1, 6'd3, 1, 6'd44); tick();
        n_checks++; if (free_count !== 6'd27) begin n_fail++; $display("FAIL wrap_count got=%0d exp=27", free_count); end
        for (int i = 0; i < 25; i++) begin
            drive(1, 0, 0, 0, 0);
            n_checks++; if (alloc_PR !== 6'(i)) begin n_fail++; $display("FAIL wrap_fill i=%0d got=%0d exp=%0d", i, alloc_PR, i); end
            tick();
        end
        drive(1, 0, 0, 0, 0);
        n_checks++; if (alloc_PR !== 6'd3) begin n_fail++; $display("FAIL wrap_first got=%0d exp=3", alloc_PR); end
        tick();
        drive(1, 0, 0, 0, 0);
        n_checks++; if (alloc_PR !== 6'd44) begin n_fail++; $display("FAIL wrap_second got=%0d exp=44", alloc_PR); end
        tick();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(0, 1, 6'd9, 0, 0); tick();
        n_checks++; if (overflow !== 1'b1 || free_count !== 6'd32 || alloc_PR !== 6'd32) begin
            n_fail++; $display("FAIL ovf_full got ovf=%b cnt=%0d pr=%0d exp 1/32/32", overflow, free_count, alloc_PR);
        end
        tick();
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        do_reset();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 1, 6'd11, 1, 6'd12); tick();
        n_checks++; if (overflow !== 1'b1 || free_count !== 6'd32) begin n_fail++; $display("FAIL ovf_partial got ovf=%b cnt=%0d exp 1/32", overflow, free_count); end
        for (int i = 0; i < 31; i++) begin drive(1, 0, 0, 0, 0); tick(); end
        n_checks++; if (alloc_PR !== 6'd11 || free_count !== 6'd1) begin n_fail++; $display("FAIL ovf_kept got pr=%0d cnt=%0d exp 11/1", alloc_PR, free_count); end
        // Alloc on full frees a slot, so a same-cycle dual push accepts one.
        do_reset();
        drive(1, 1, 6'd1, 1, 6'd2); tick();
        n_checks++; if (free_count !== 6'd32 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_popfirst got cnt=%0d ovf=%b exp 32/1", free_count, overflow); end
    endtask

    task automatic test_random();
        int alloc_pct;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            alloc_pct = ((c / 100) % 2 == 0) ? 85 : 20;
            drive(($urandom_range(99) < alloc_pct), ($urandom_range(99) < 45), 6'($urandom_range(63)),
                  ($urandom_range(99) < 30), 6'($urandom_range(63)));
            n_checks++; if (alloc_gnt !== (alloc_req && exp_q.size() > 0)) begin
                n_fail++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, alloc_gnt, (alloc_req && exp_q.size() > 0));
            end
            if (exp_q.size() > 0) begin
                n_checks++; if (alloc_PR !== exp_q[0]) begin n_fail++; $display("FAIL rand_pr c=%0d got=%0d exp=%0d", c, alloc_PR, exp_q[0]); end
            end
            n_checks++; if (free_count !== 6'(exp_q.size()) || empty !== (exp_q.size() == 0) || full !== (exp_q.size() == 32)) begin
                n_fail++; $display("FAIL rand_count c=%0d got cnt=%0d e=%b f=%b exp cnt=%0d", c, free_count, empty, full, exp_q.size());
            end
            n_checks++; if (overflow !== model_ovf) begin n_fail++; $display("FAIL rand_ovf c=%0d got=%b exp=%b", c, overflow, model_ovf); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_fifo_order();
        test_simultaneous();
        test_wrap();
        test_overflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the out-of-order pipeline's rename stage. It hands a free physical register (PR) to rename/dispatch for each instruction that writes a destination. It takes PRs back from the reorder buffer when an instruction retires (the previous mapping is released) or is flushed (the new mapping is squashed). Internally it is a circular FIFO of PR numbers with one pop port and two push ports.

## Interface
- PR_WIDTH, 6, physical register number width (64 PRs)
- DEPTH, 32, FIFO capacity; equals the number of non-architecturally-mapped PRs
- INIT_BASE, 32, first PR number loaded at reset

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- alloc_req  in  1  rename requests one PR this cycle
- alloc_PR  out  PR_WIDTH  PR at FIFO head; valid when empty=0
- alloc_gnt  out  1  alloc_req & ~empty; the pop happens at the next edge
- retire_reg  in  1  ROB retire; push PR_old_RT
- PR_old_RT  in  PR_WIDTH  old PR freed at retire
- rd_flush  in  1  ROB flush walk; push PR_new_flush
- PR_new_flush  in  PR_WIDTH  new PR returned by squashed instruction
- free_count  out  6  number of valid entries, 0..DEPTH
- empty  out  1  free_count==0; rename must stall
- full  out  1  free_count==DEPTH
- overflow  out  1  sticky; set when a push is dropped for lack of space

## Operation
- Storage: DEPTH x PR_WIDTH array, head/tail pointers of log2(DEPTH) bits, wrap modulo DEPTH.
- Reset (rst=1 at edge):
  - mem[i]=INIT_BASE+i; head=0; tail=0; free_count=DEPTH; overflow=0.
  - Resulting outputs: alloc_PR=INIT_BASE, empty=0, full=1, alloc_gnt=alloc_req.
  - rst overrides all same-cycle requests and aborts any mid-operation state.
- Pop: when alloc_gnt=1, head advances by 1 and free_count decrements.
  - alloc_req with empty=1 is ignored: no pointer or count change, alloc_gnt=0.
- Push order within one cycle: pop first, then retire, then flush.
  - Each push is accepted only if the running count is < DEPTH.
  - First accepted push writes mem[tail]; a second accepted push writes mem[tail+1].
  - tail advances by the number of accepted pushes.
- free_count_next = free_count − pop + accepted_pushes.
- A dropped push sets overflow. overflow clears only on rst.
- No bypass: a PR pushed in cycle N is allocatable no earlier than cycle N+1. An alloc while empty is refused even if a push arrives the same cycle.
- PR values are stored unchecked: no duplicate detection, no PR-0 special case.

## Timing
- alloc_PR, alloc_gnt, empty, full and free_count are combinational from registered state (plus alloc_req for alloc_gnt). Zero-cycle request-to-grant.
- Pushes, pops and overflow take effect at the rising edge; the updated state is visible in the following cycle.
- Simultaneous retire + flush + alloc in one cycle is legal and must update count correctly, e.g. count 1 → 2.
- Wrap-around: head and tail roll from DEPTH−1 to 0 with no bubble. A dual push straddling the wrap writes mem[DEPTH−1] and mem[0].
- Throughput: 1 allocation and 2 frees per cycle sustained.

## Test plan
- Reset: rst high 1 cycle → alloc_PR=32, free_count=32, full=1, empty=0, overflow=0. Repeat rst after 10 allocs → same values restored.
- Drain: alloc_req=1 for 33 cycles → alloc_PR sequence 32..63 on grants 1..32; empty=1 after the 32nd edge; 33rd request gives alloc_gnt=0 and free_count stays 0.
- FIFO order: from empty, retire PR 5, then retire PR 6, then 2 allocs → alloc_PR 5 then 6, free_count 2→1→0.
- Simultaneous events: free_count=1, head PR 50; same cycle alloc_req, retire PR 7, flush PR 40 → alloc_gnt=1 (gets 50), next cycle free_count=2; next allocs return 7 then 40.
- Wrap: tail at 31, retire PR 3 + flush PR 44 together → mem[31]=3, mem[0]=44, tail=1; subsequent allocs return them in that order.
- Overflow: right after reset (full), retire PR 9 → dropped, overflow=1, free_count=32. Retire + flush with free_count=31 → retire accepted, flush dropped, overflow=1.
